mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store front-end between the EX stage and the word-wide data memory. Accepts one load or store request at a time and handles byte and halfword access: sign/zero extension for loads, read-modify-write for sub-word stores. Also checks alignment. It drives the memory's `addr`/`datain`/`ReadWrite` inputs and consumes its combinational `dataout`.

## Interface
- No parameters.
- `Clock` in 1: single clock; every register updates on its rising edge.
- `Reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle; a request is accepted when `req_valid & req_ready`.
- `req_op` in 3: encodings are 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; SB uses [7:0], SH uses [15:0].
- `resp_done` out 1: one-cycle pulse when the request completes.
- `resp_rdata` out 32: load result; valid while `resp_done`=1, 0 for stores and errors.
- `resp_err` out 1: misaligned access; valid while `resp_done`=1.
- `mem_addr` out 32: to memory `addr`; always `{lat_addr[31:2],2'b00}`.
- `mem_datain` out 32: to memory `datain`.
- `mem_ReadWrite` out 1: to memory `ReadWrite`; 1 = write, 0 = read.
- `mem_dataout` in 32: from memory `dataout`, combinational read data.

## Operation
- Little-endian lanes. Byte k = bits [8k+7:8k], selected by `addr[1:0]`. Half h = bits [16h+15:16h], selected by `addr[1]`.
- On accept, latch op/addr/wdata into `lat_*` and leave IDLE.
- States: IDLE, RD, WR, RESP.
- Transitions:
  - IDLE → RD for loads, SB and SH.
  - IDLE → WR for SW.
  - IDLE → RESP on a misaligned request.
  - RD → RESP for loads; RD → WR for SB and SH.
  - WR → RESP.
  - RESP → IDLE.
- RD: `mem_ReadWrite`=0. Capture `mem_dataout` into `rd_word` at the end of the cycle.
- Load extraction from `rd_word`:
  - LW: the whole word.
  - LH: sign-extend the selected half. LHU: zero-extend it.
  - LB: sign-extend the selected byte. LBU: zero-extend it.
- The result is registered into `resp_rdata` on the RD → RESP edge.
- WR: `mem_ReadWrite`=1 and `mem_datain` set as follows:
  - SW: `lat_wdata`.
  - SH: `rd_word` with the selected half replaced by `lat_wdata[15:0]`.
  - SB: `rd_word` with the selected byte replaced by `lat_wdata[7:0]`.
- `mem_ReadWrite` = (state==WR) & ~Reset, so a write is suppressed in any cycle where Reset is high.
- Outside WR, `mem_datain`=0.
- Misaligned when:
  - LW/SW with `addr[1:0]`≠0;
  - LH/LHU/SH with `addr[0]`=1.
- A misaligned request makes no memory access. Result: `resp_err`=1, `resp_rdata`=0.
- Only one request is outstanding. `req_*` inputs are ignored outside IDLE.

## Timing
- Reset (sampled at an edge) puts state in IDLE with:
  - `req_ready`=1, `resp_done`=0, `resp_err`=0, `resp_rdata`=0;
  - `mem_ReadWrite`=0, `mem_datain`=0, `rd_word`=0.
- Reset asserted mid-operation abandons the request: no `resp_done`, no write.
- `req_ready` = (state==IDLE), a combinational decode of the registered state.
- Latency from the accept edge to the `resp_done` cycle:
  - loads: 2 cycles (RD, RESP);
  - SW: 2 cycles (WR, RESP);
  - SB/SH: 3 cycles (RD, WR, RESP);
  - misaligned: 1 cycle (RESP).
- The next request can be accepted in the cycle after RESP. Peak throughput: one load per 3 cycles.
- Memory write data is committed on the rising edge that ends the WR cycle.

## Configuration
- `MAU_ALIGN_CHECK_EN` defined:
  - misalignment is detected as described in Operation;
  - `resp_err` is driven.
- `MAU_ALIGN_CHECK_EN` undefined:
  - `resp_err` is tied to 0 and no error path exists;
  - the latched address is force-aligned: `addr[1:0]` cleared for LW/SW, `addr[0]` cleared for LH/LHU/SH;
  - the access proceeds normally.

## Test plan
Memory preload: ram[i]=i*i.
- LB at 0x3C (word 15 = 0xE1) → `resp_rdata`=0xFFFFFFE1. LBU at 0x3C → 0x000000E1. `resp_done` 2 cycles after accept.
- LH at 0x7C (word 31 = 0x3C1) → 0x000003C1. LW at 0x14 → 0x00000019.
- SB 0xAA at 0x15, then LW at 0x14 → 0x0000AA19. Then SH 0x1234 at 0x16, then LW at 0x14 → 0x1234AA19. Each store has `resp_done` 3 cycles after accept and exactly one `mem_ReadWrite` cycle.
- SW 0xDEADBEEF at 0x20, then LW at 0x20 → 0xDEADBEEF. `resp_done` 2 cycles after accept.
- With `MAU_ALIGN_CHECK_EN`: LW at 0x02 → `resp_err`=1, `resp_rdata`=0, `resp_done` 1 cycle after accept, `mem_ReadWrite` never high. Without the macro: LW at 0x02 → 0x00000000 (word 0), `resp_err`=0.
- SB 0xFF at 0x08 with Reset asserted during the WR cycle → `mem_ReadWrite` stays 0, no `resp_done`, `req_ready`=1 after the reset edge, LW at 0x08 → 0x00000004.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front-end between EX and a word-wide data memory.
// Handles LW/LH/LHU/LB/LBU/SW/SH/SB with little-endian lanes, sign/zero
// extension on loads and read-modify-write for sub-word stores.
// Optional feature macro: MAU_ALIGN_CHECK_EN
//   defined   -> misaligned requests complete immediately with resp_err=1
//   undefined -> resp_err tied low, latched address is force-aligned instead
module mem_access_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_done,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  output logic        mem_ReadWrite,
  input  logic [31:0] mem_dataout
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state;
  logic [2:0]  lat_op;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] rd_word;

  logic [31:0] addr_in;
  logic        req_misaligned;
  logic        lat_is_load;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_result;
  logic [31:0] merged_word;

`ifdef MAU_ALIGN_CHECK_EN
  logic err_q;

  // A request is misaligned when its address is not a multiple of its access size
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
    logic m;
    m = 1'b0;
    case (op)
      OP_LW, OP_SW:         m = (a != 2'b00);
      OP_LH, OP_LHU, OP_SH: m = a[0];
      default:              m = 1'b0;
    endcase
    return m;
  endfunction

  assign req_misaligned = misaligned(req_op, req_addr[1:0]);
  assign addr_in        = req_addr;
  assign resp_err       = err_q;
`else
  // Without the check, low address bits that would misalign the access are dropped
  function automatic logic [31:0] force_align(input logic [2:0] op, input logic [31:0] a);
    logic [31:0] r;
    r = a;
    case (op)
      OP_LW, OP_SW:         r[1:0] = 2'b00;
      OP_LH, OP_LHU, OP_SH: r[0]   = 1'b0;
      default:              r      = a;
    endcase
    return r;
  endfunction

  assign req_misaligned = 1'b0;
  assign addr_in        = force_align(req_op, req_addr);
  assign resp_err       = 1'b0;
`endif

  assign req_ready     = (state == IDLE);
  assign mem_addr      = {lat_addr[31:2], 2'b00};
  assign mem_ReadWrite = (state == WR) & ~Reset;
  assign mem_datain    = (state == WR) ? merged_word : 32'h0;
  assign lat_is_load   = (lat_op <= OP_LBU);

  // Extract the load result from the word being captured into rd_word this cycle
  always_comb begin
    sel_byte    = mem_dataout[{lat_addr[1:0], 3'b000} +: 8];
    sel_half    = mem_dataout[{lat_addr[1], 4'b0000} +: 16];
    load_result = 32'h0;
    case (lat_op)
      OP_LW:   load_result = mem_dataout;
      OP_LH:   load_result = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  load_result = {16'h0, sel_half};
      OP_LB:   load_result = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  load_result = {24'h0, sel_byte};
      default: load_result = 32'h0;
    endcase
  end

  // Build the write word: full store data for SW, otherwise merge into the word read in RD
  always_comb begin
    merged_word = rd_word;
    case (lat_op)
      OP_SW:   merged_word = lat_wdata;
      OP_SH:   merged_word[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
      OP_SB:   merged_word[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
      default: merged_word = rd_word;
    endcase
  end

  // Request sequencer: IDLE -> (RD) -> (WR) -> RESP -> IDLE, with registered response
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      lat_op     <= OP_LW;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
      rd_word    <= 32'h0;
      resp_done  <= 1'b0;
      resp_rdata <= 32'h0;
`ifdef MAU_ALIGN_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      resp_done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_op     <= req_op;
            lat_addr   <= addr_in;
            lat_wdata  <= req_wdata;
            resp_rdata <= 32'h0;
            if (req_misaligned) begin
`ifdef MAU_ALIGN_CHECK_EN
              err_q <= 1'b1;
`endif
              resp_done <= 1'b1;
              state     <= RESP;
            end else if (req_op == OP_SW) begin
              state <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          rd_word <= mem_dataout;
          if (lat_is_load) begin
            resp_rdata <= load_result;
            resp_done  <= 1'b1;
            state      <= RESP;
          end else begin
            state <= WR;
          end
        end
        WR: begin
          resp_rdata <= 32'h0;
          resp_done  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          resp_rdata <= 32'h0;
`ifdef MAU_ALIGN_CHECK_EN
          err_q      <= 1'b0;
`endif
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed requests against a small word memory
// model (ram[i]=i*i); expected responses go into a scoreboard queue and a
// monitor compares them whenever resp_done is seen.
module tb_mem_access_unit;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          writes;
    int          setupCyc;
  } exp_t;

  logic        Clock;
  logic        Reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_done;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_datain;
  logic        mem_ReadWrite;
  logic [31:0] mem_dataout;

  logic [31:0] ram [0:63];
  logic        preload;
  int          cyc;
  int          wrCount;
  int          testsRun;
  int          testsFailed;
  int          reqId;
  exp_t        sbq[$];

  mem_access_unit dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_done    (resp_done),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_datain   (mem_datain),
    .mem_ReadWrite(mem_ReadWrite),
    .mem_dataout  (mem_dataout)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Cycle counter used to measure latency from request presentation to resp_done
  always @(posedge Clock) cyc <= cyc + 1;

  // Word memory: combinational read, write on the edge ending a ReadWrite cycle
  assign mem_dataout = ram[mem_addr[7:2]];
  always @(posedge Clock) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) ram[i] <= i * i;
    end else if (mem_ReadWrite) begin
      ram[mem_addr[7:2]] <= mem_datain;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: count write cycles and check each response against the scoreboard
  always @(negedge Clock) begin
    exp_t e;
    if (mem_ReadWrite) wrCount++;
    if (resp_done) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected_resp_done", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        checkOutput($sformatf("rdata#%0d", e.id), resp_rdata, e.rdata);
        checkOutput($sformatf("err#%0d", e.id), {31'h0, resp_err}, {31'h0, e.err});
        checkOutput($sformatf("latency#%0d", e.id), 32'(cyc - e.setupCyc), 32'(e.lat));
        checkOutput($sformatf("writes#%0d", e.id), 32'(wrCount), 32'(e.writes));
        wrCount = 0;
      end
    end
  end

  // Issue one request at a negedge and wait (bounded) until its response is consumed
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expRdata, input logic expErr, input int expLat,
                               input int expWrites);
    exp_t e;
    int   n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge Clock);
      n++;
    end
    if (!req_ready) begin
      checkOutput("ready_timeout", 32'd0, 32'd1);
      return;
    end
    reqId++;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    e.id       = reqId;
    e.rdata    = expRdata;
    e.err      = expErr;
    e.lat      = expLat;
    e.writes   = expWrites;
    e.setupCyc = cyc;
    sbq.push_back(e);
    @(negedge Clock);
    req_valid = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge Clock);
      n++;
    end
    if (sbq.size() != 0) begin
      checkOutput($sformatf("resp_timeout#%0d", reqId), 32'd0, 32'd1);
      sbq.delete();
    end
  endtask

  initial begin
    cyc = 0;
    wrCount = 0;
    testsRun = 0;
    testsFailed = 0;
    reqId = 0;
    Reset = 1'b1;
    preload = 1'b1;
    req_valid = 1'b0;
    req_op = OP_LW;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    repeat (3) @(negedge Clock);
    checkOutput("rst_req_ready", {31'h0, req_ready}, 32'd1);
    checkOutput("rst_resp_done", {31'h0, resp_done}, 32'd0);
    checkOutput("rst_resp_err", {31'h0, resp_err}, 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
    checkOutput("rst_mem_rw", {31'h0, mem_ReadWrite}, 32'd0);
    checkOutput("rst_mem_datain", mem_datain, 32'h0);
    Reset = 1'b0;
    preload = 1'b0;
    @(negedge Clock);

    // Loads from the preloaded image
    applyStimulus(OP_LB,  32'h3C, 32'h0, 32'hFFFFFFE1, 1'b0, 2, 0);
    applyStimulus(OP_LBU, 32'h3C, 32'h0, 32'h000000E1, 1'b0, 2, 0);
    applyStimulus(OP_LH,  32'h7C, 32'h0, 32'h000003C1, 1'b0, 2, 0);
    applyStimulus(OP_LW,  32'h14, 32'h0, 32'h00000019, 1'b0, 2, 0);

    // Sub-word stores via read-modify-write, then read back in several widths
    applyStimulus(OP_SB,  32'h15, 32'h000000AA, 32'h0, 1'b0, 3, 1);
    applyStimulus(OP_LW,  32'h14, 32'h0, 32'h0000AA19, 1'b0, 2, 0);
    applyStimulus(OP_SH,  32'h16, 32'h00001234, 32'h0, 1'b0, 3, 1);
    applyStimulus(OP_LW,  32'h14, 32'h0, 32'h1234AA19, 1'b0, 2, 0);
    applyStimulus(OP_LH,  32'h14, 32'h0, 32'hFFFFAA19, 1'b0, 2, 0);
    applyStimulus(OP_LHU, 32'h14, 32'h0, 32'h0000AA19, 1'b0, 2, 0);
    applyStimulus(OP_LB,  32'h15, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0);
    applyStimulus(OP_LH,  32'h16, 32'h0, 32'h00001234, 1'b0, 2, 0);

    // Full-word store and byte lanes of the result
    applyStimulus(OP_SW,  32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
    applyStimulus(OP_LW,  32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);
    applyStimulus(OP_LB,  32'h23, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 0);
    applyStimulus(OP_LBU, 32'h22, 32'h0, 32'h000000AD, 1'b0, 2, 0);

    // Top byte lane store and sign extension of the upper half
    applyStimulus(OP_SB,  32'h3F, 32'h00000080, 32'h0, 1'b0, 3, 1);
    applyStimulus(OP_LW,  32'h3C, 32'h0, 32'h800000E1, 1'b0, 2, 0);
    applyStimulus(OP_LH,  32'h3E, 32'h0, 32'hFFFF8000, 1'b0, 2, 0);

    // Misaligned accesses
`ifdef MAU_ALIGN_CHECK_EN
    applyStimulus(OP_LW,  32'h02, 32'h0, 32'h0, 1'b1, 1, 0);
    applyStimulus(OP_LH,  32'h7D, 32'h0, 32'h0, 1'b1, 1, 0);
    applyStimulus(OP_SW,  32'h21, 32'h55555555, 32'h0, 1'b1, 1, 0);
    applyStimulus(OP_LW,  32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);
`else
    applyStimulus(OP_LW,  32'h02, 32'h0, 32'h00000000, 1'b0, 2, 0);
    applyStimulus(OP_LH,  32'h7D, 32'h0, 32'h000003C1, 1'b0, 2, 0);
`endif

    // SB abandoned by a reset during its WR cycle
    req_valid = 1'b1;
    req_op    = OP_SB;
    req_addr  = 32'h08;
    req_wdata = 32'h000000FF;
    @(negedge Clock);
    req_valid = 1'b0;
    @(posedge Clock);
    #1 Reset = 1'b1;
    @(negedge Clock);
    checkOutput("rst_wr_datain", mem_datain, 32'h000000FF);
    checkOutput("rst_wr_suppressed", {31'h0, mem_ReadWrite}, 32'd0);
    @(negedge Clock);
    checkOutput("rst_abandon_ready", {31'h0, req_ready}, 32'd1);
    checkOutput("rst_abandon_done", {31'h0, resp_done}, 32'd0);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    applyStimulus(OP_LW,  32'h08, 32'h0, 32'h00000004, 1'b0, 2, 0);

    repeat (3) @(negedge Clock);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
